// File: rtl/seg7_scan_driver_if.sv
// Bundles the load-side inputs and the scan outputs of the 7-segment scan driver.
interface seg7_scan_driver_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   digit_en;
   logic                lz_blank;
   logic                load;
   logic [7:0]          SEG;
   logic [DIGITS-1:0]   AN;
   logic                frame_done;
   logic                pend;

   modport master (
      output data, dp, digit_en, lz_blank, load,
      input  SEG, AN, frame_done, pend
   );

   modport slave (
      input  data, dp, digit_en, lz_blank, load,
      output SEG, AN, frame_done, pend
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display scanner with double-buffered frames, leading-zero
// blanking and per-digit enables. Frames swap only at the scan wrap.
module seg7_scan_driver #(
   parameter int DIGITS     = 8,
   parameter int CLK_DIV    = 100000,
   parameter bit ACTIVE_LOW = 1
) (
   input logic                clk,
   input logic                rst,
   seg7_scan_driver_if.slave  bus
);
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int FW    = 6 * DIGITS + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h18;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   // Frame word layout: {lz_blank, digit_en, dp, data}
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [FW-1:0]     pnd_q, pnd_d, disp_q, disp_d;
   logic              pend_q, pend_d;
   logic              frame_done_q;
   logic [7:0]        seg_q, seg_d, seg_al;
   logic [DIGITS-1:0] an_q, an_d, an_al;
   logic              tc, boundary;

   logic [4*DIGITS-1:0] d_data;
   logic [DIGITS-1:0]   d_dp, d_en, nz, blank, sel;
   logic                d_lz;
   logic [3:0]          nib;

   assign tc       = (cnt_q == CNT_LAST);
   assign boundary = tc && (idx_q == IDX_LAST);

   always_comb begin
      cnt_d  = tc ? '0 : cnt_q + CNT_W'(1);
      idx_d  = idx_q;
      if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      pnd_d  = bus.load ? {bus.lz_blank, bus.digit_en, bus.dp, bus.data} : pnd_q;
      disp_d = boundary ? pnd_d : disp_q;
      pend_d = boundary ? 1'b0 : (bus.load ? 1'b1 : pend_q);
   end

   // Outputs are decoded from next-state so SEG/AN move together with idx.
   assign d_data = disp_d[4*DIGITS-1:0];
   assign d_dp   = disp_d[5*DIGITS-1:4*DIGITS];
   assign d_en   = disp_d[6*DIGITS-1:5*DIGITS];
   assign d_lz   = disp_d[6*DIGITS];

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nz[gi]    = d_en[gi] && (d_data[4*gi +: 4] != 4'h0);
         assign blank[gi] = (gi != 0) && d_lz && !d_dp[gi] && !(|(nz >> gi));
         assign sel[gi]   = (idx_d == IDX_W'(gi));
      end
   endgenerate

   assign nib = d_data[{idx_d, 2'b00} +: 4];

   always_comb begin
      seg_al = 8'hFF;
      an_al  = {DIGITS{1'b1}};
      if (d_en[idx_d]) begin
         an_al = ~sel;
         if (!blank[idx_d]) seg_al = {~d_dp[idx_d], hex7(nib)};
      end
      seg_d = ACTIVE_LOW ? seg_al : ~seg_al;
      an_d  = ACTIVE_LOW ? an_al : ~an_al;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pnd_q        <= '0;
         disp_q       <= '0;
         pend_q       <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pnd_q        <= pnd_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         frame_done_q <= boundary;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign bus.SEG        = seg_q;
   assign bus.AN         = an_q;
   assign bus.frame_done = frame_done_q;
   assign bus.pend       = pend_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scan driver bench: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized loads and resets.
module tb_seg7_scan_driver;
   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 4;
   localparam int FRAME   = DIGITS * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

   seg7_scan_driver #(
      .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Model: n = clock edges since reset; scan position derives from n alone.
   int          n = 0;
   bit          m_rst = 1'b1;
   logic [15:0] m_data, p_data;
   logic [3:0]  m_dp, m_en, p_dp, p_en;
   logic        m_lz, p_lz, m_pend, m_fd;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s n=%0d got=%h expected=%h", name, n, got, exp);
      end
   endtask

   task automatic model_out(output logic [7:0] s, output logic [3:0] a);
      int idx, h;
      logic [3:0] v;
      s = 8'hFF;
      a = 4'hF;
      if (m_rst) return;
      idx = (n / CLK_DIV) % DIGITS;
      h = 0;
      for (int i = 0; i < DIGITS; i++)
         if (m_en[i] && m_data[4*i +: 4] != 4'h0) h = i;
      if (!m_en[idx]) return;
      a = ~(4'b0001 << idx);
      if (m_lz && idx > h && !m_dp[idx]) return;
      v = m_data[4*idx +: 4];
      s = {~m_dp[idx], hex_tab[v]};
   endtask

   task automatic tick();
      logic [7:0] es;
      logic [3:0] ea;
      bit bnd;
      @(posedge clk);
      if (rst) begin
         n = 0; m_rst = 1'b1;
         m_data = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
         p_data = '0; p_dp = '0; p_en = '0; p_lz = 1'b0;
         m_pend = 1'b0; m_fd = 1'b0;
      end else begin
         bnd = ((n % FRAME) == FRAME - 1);
         if (bus.load) begin
            p_data = bus.data; p_dp = bus.dp; p_en = bus.digit_en; p_lz = bus.lz_blank;
         end
         if (bnd) begin
            m_data = p_data; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
            m_pend = 1'b0;
         end else if (bus.load) m_pend = 1'b1;
         m_fd = bnd;
         n++;
         m_rst = 1'b0;
      end
      @(negedge clk);
      model_out(es, ea);
      chk("seg", {24'h0, bus.SEG}, {24'h0, es});
      chk("an", {28'h0, bus.AN}, {28'h0, ea});
      chk("frame_done", {31'h0, bus.frame_done}, {31'h0, m_fd});
      chk("pend", {31'h0, bus.pend}, {31'h0, m_pend});
   endtask

   task automatic run_until(input int target);
      int guard = 0;
      while (n < target && guard < 1000) begin
         tick();
         guard++;
      end
      chk("run_until_reached", n, target);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                          input logic lz);
      bus.data = d; bus.dp = p; bus.digit_en = e; bus.lz_blank = lz; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   initial begin
      bus.data = '0; bus.dp = '0; bus.digit_en = '0; bus.lz_blank = 1'b0; bus.load = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_an", {28'h0, bus.AN}, 32'hF);
      chk("rst_seg", {24'h0, bus.SEG}, 32'hFF);
      chk("rst_pend", {31'h0, bus.pend}, 32'h0);
      rst = 1'b0;

      // 12AF with all digits enabled
      run_until(5);
      do_load(16'h12AF, 4'h0, 4'hF, 1'b0);
      chk("lit_pend_mid", {31'h0, bus.pend}, 32'h1);
      run_until(33); chk("lit_d0_an", {28'h0, bus.AN}, 32'hE); chk("lit_d0_seg", {24'h0, bus.SEG}, 32'h8E);
      run_until(37); chk("lit_d1_an", {28'h0, bus.AN}, 32'hD); chk("lit_d1_seg", {24'h0, bus.SEG}, 32'h88);
      run_until(41); chk("lit_d2_an", {28'h0, bus.AN}, 32'hB); chk("lit_d2_seg", {24'h0, bus.SEG}, 32'hA4);
      run_until(45); chk("lit_d3_an", {28'h0, bus.AN}, 32'h7); chk("lit_d3_seg", {24'h0, bus.SEG}, 32'hF9);
      run_until(48); chk("lit_fd_48", {31'h0, bus.frame_done}, 32'h1);
      tick();        chk("lit_fd_49", {31'h0, bus.frame_done}, 32'h0);

      // leading-zero blanking with a lit dp on a zero digit
      run_until(50);
      do_load(16'h0070, 4'b0100, 4'hF, 1'b1);
      run_until(65); chk("lz_d0", {24'h0, bus.SEG}, 32'hC0);
      run_until(69); chk("lz_d1", {24'h0, bus.SEG}, 32'hF8);
      run_until(73); chk("lz_d2", {24'h0, bus.SEG}, 32'h40);
      run_until(77); chk("lz_d3", {24'h0, bus.SEG}, 32'hFF); chk("lz_d3_an", {28'h0, bus.AN}, 32'h7);

      // mid-frame load keeps old data until the boundary
      run_until(82);
      do_load(16'h5555, 4'h0, 4'hF, 1'b0);
      chk("mid_pend", {31'h0, bus.pend}, 32'h1);
      chk("mid_old_seg", {24'h0, bus.SEG}, 32'hC0);
      run_until(96); chk("mid_pend_clr", {31'h0, bus.pend}, 32'h0);
      tick();        chk("mid_new_seg", {24'h0, bus.SEG}, 32'h92);

      // load on the boundary cycle, second load three cycles later
      run_until(111);
      do_load(16'h3333, 4'h0, 4'hF, 1'b0);
      chk("bnd_pend", {31'h0, bus.pend}, 32'h0);
      tick(); tick();
      do_load(16'h4444, 4'h0, 4'hF, 1'b0);
      chk("bnd_pend2", {31'h0, bus.pend}, 32'h1);
      run_until(116); chk("bnd_first", {24'h0, bus.SEG}, 32'hB0);
      run_until(129); chk("bnd_second", {24'h0, bus.SEG}, 32'h99);

      // partial digit enables
      run_until(130);
      do_load(16'h1234, 4'h0, 4'b1010, 1'b0);
      run_until(145); chk("en_d0_an", {28'h0, bus.AN}, 32'hF); chk("en_d0_seg", {24'h0, bus.SEG}, 32'hFF);
      run_until(149); chk("en_d1_an", {28'h0, bus.AN}, 32'hD); chk("en_d1_seg", {24'h0, bus.SEG}, 32'hB0);
      run_until(153); chk("en_d2_an", {28'h0, bus.AN}, 32'hF);
      run_until(160); chk("en_fd", {31'h0, bus.frame_done}, 32'h1);

      // reset mid-dwell with a pending load
      run_until(162);
      do_load(16'h9999, 4'h0, 4'hF, 1'b0);
      run_until(169);
      chk("rst_pre_pend", {31'h0, bus.pend}, 32'h1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst1_an", {28'h0, bus.AN}, 32'hF);
      chk("rst1_seg", {24'h0, bus.SEG}, 32'hFF);
      chk("rst1_pend", {31'h0, bus.pend}, 32'h0);
      run_until(20);

      // randomized loads, sparse nibbles and occasional resets
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] d;
         for (int k = 0; k < 4; k++)
            d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         rst          = ($urandom_range(0, 399) == 0);
         bus.load     = ($urandom_range(0, 7) == 0);
         bus.data     = d;
         bus.dp       = 4'($urandom_range(0, 15));
         bus.digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         bus.lz_blank = 1'($urandom_range(0, 1));
         tick();
      end
      rst = 1'b0;
      bus.load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter CLK_DIV, default 100000: dwell time per digit in clk cycles, minimum 2.
REQ-003 Parameter ACTIVE_LOW, default 1: output polarity; 1 means SEG and AN are low-active, 0 means both are high-active.
REQ-004 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 data  in  4*DIGITS  hex nibbles; nibble i (data[4i+3:4i]) drives digit i; digit 0 is rightmost.
REQ-007 dp  in  DIGITS  decimal-point request per digit; 1 = lit.
REQ-008 digit_en  in  DIGITS  per-digit enable; 0 = digit dark.
REQ-009 lz_blank  in  1  1 = leading-zero blanking enabled.
REQ-010 load  in  1  single-cycle strobe; captures data, dp, digit_en and lz_blank into the pending register.
REQ-011 SEG  out  8  segment drive, ordered {dp,g,f,e,d,c,b,a}; registered.
REQ-012 AN  out  DIGITS  digit select, one-hot active; registered.
REQ-013 frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.
REQ-014 pend  out  1  1 = a captured load is not yet displayed.

Function
REQ-015 Divider: count 0..CLK_DIV-1, then wrap; the terminal count (tc) SHALL advance the digit index idx by 1.
REQ-016 idx SHALL wrap from DIGITS-1 to 0; frame_done SHALL be 1 in the cycle after the tc that wraps idx to 0.
REQ-017 load SHALL copy the inputs into the pending register and set pend=1; a later load before the frame boundary SHALL overwrite the pending contents (last load wins).
REQ-018 Display register SHALL update from pending only at a frame boundary (tc with idx=DIGITS-1), then clear pend; a displayed frame never mixes old and new data.
REQ-019 If load and the frame boundary fall in the same cycle, the frame SHALL use the new load's values and pend SHALL end at 0.
REQ-020 Hex decode, active-low pattern (bits 6:0 = g..a), 0..F: 40,79,24,30,19,12,02,78,00,18,08,03,46,21,06,0E; bit7 SHALL be 0 when dp is lit, otherwise 1.
REQ-021 Blanked digit: SEG=8'hFF (active-low sense), and its AN position stays active.
REQ-022 Leading-zero blanking: when lz_blank=1, digits above the highest nonzero enabled nibble SHALL be blanked unless their dp is lit; digit 0 SHALL never be blanked by this rule.
REQ-023 When digit_en[idx]=0, AN SHALL be all-inactive and SEG all-off for that dwell; the scan timing SHALL not change.
REQ-024 SEG and AN SHALL reflect the new idx exactly 1 cycle after tc; both SHALL change in the same cycle (no ghosting skew).
REQ-025 When ACTIVE_LOW=0, SEG and AN SHALL be the bitwise inverses of the active-low values.

Reset
REQ-026 While rst=1: divider=0, idx=0, display and pending registers=0, pend=0 and frame_done=0; SEG and AN SHALL be all-inactive (8'hFF and all-ones when ACTIVE_LOW=1).
REQ-027 A rst during a dwell or with pend=1 SHALL discard the pending load; the first cycle after rst is deasserted SHALL restart the count at digit 0 with a 0 display.
REQ-028 After reset with no load, the display is all-zero and digit_en is 0, so all digits SHALL be dark.

Verification (DIGITS=4, CLK_DIV=4, ACTIVE_LOW=1)
REQ-029 Load data=16'h12AF, dp=0, digit_en=4'hF, lz_blank=0, then run 2 frames -> over the second frame, AN/SEG sequence SHALL be 1110/8E, 1101/88, 1011/A4, 0111/F9, each held for 4 cycles; frame_done SHALL pulse once every 16 cycles.
REQ-030 Load data=16'h0070, lz_blank=1, digit_en=F, dp=4'b0100 -> digit3 blank (FF), digit2 SHALL show C0 with bit7 cleared (40), digit1=F8, digit0=C0.
REQ-031 Load in mid-frame -> pend=1 and the old data SHALL be shown until the boundary; pend=0 and the new data SHALL be shown from the next digit 0.
REQ-032 Load asserted on the boundary cycle, then a second load 3 cycles later -> the frame SHALL show the first load, pend=1 and the second load SHALL be applied at the next boundary.
REQ-033 digit_en=4'b1010 -> AN SHALL be 1111 during the digit0 and digit2 dwells, and the frame period SHALL stay 16 cycles.
REQ-034 Assert rst for 1 cycle with idx=2 and pend=1 -> next cycle: AN=1111, SEG=FF, pend=0; scanning SHALL restart at digit 0.
